// File: rtl/adder72_seg_sequencer_if.sv
// Operand/result valid-ready streams plus the shared carry-chain segment hookup.
// slave = sequencer side, master = environment (producer/consumer + chain segment).
interface adder72_seg_sequencer_if #(
  parameter int unsigned W     = 72,
  parameter int unsigned SEG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_cin;
  logic             in_sub;

  logic [SEG_W-1:0] chain_s;
  logic [SEG_W-1:0] chain_d;
  logic             chain_ci;
  logic [SEG_W-1:0] chain_sum;
  logic             chain_co;

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, chain_sum, chain_co, out_ready,
    output in_ready, chain_s, chain_d, chain_ci, out_valid, out_sum, out_cout, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, chain_sum, chain_co, out_ready,
    input  in_ready, chain_s, chain_d, chain_ci, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/adder72_seg_sequencer.sv
// Runs one W-bit add/sub as NSEG back-to-back passes through a single shared SEG_W carry-chain
// segment, feeding each pass's carry-out into the next pass's carry-in.
module adder72_seg_sequencer #(
  parameter int unsigned W     = 72,
  parameter int unsigned SEG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adder72_seg_sequencer_if.slave bus
);

  localparam int unsigned NSEG   = W / SEG_W;
  localparam int unsigned SEG_CW = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state,     w_state;
  logic [SEG_CW-1:0]  r_seg,       w_seg;
  logic [W-1:0]       r_a,         w_a;
  logic [W-1:0]       r_b,         w_b;
  logic [W-1:0]       r_sum,       w_sum;
  logic               r_cout,      w_cout;
  logic               r_ovf,       w_ovf;
  logic               r_out_valid, w_out_valid;
  logic               r_in_ready,  w_in_ready;
  logic [SEG_W-1:0]   r_chain_s,   w_chain_s;
  logic [SEG_W-1:0]   r_chain_d,   w_chain_d;
  logic               r_chain_ci,  w_chain_ci;  // doubles as the running inter-pass carry

  logic [W-1:0]       w_beff_in;
  logic               w_ci_in;
  int unsigned        w_nxt_idx;

  function automatic logic [SEG_W-1:0] seg_slice(input logic [W-1:0] v, input int unsigned k);
    return v[k*SEG_W +: SEG_W];
  endfunction

  // Next-state and next-output logic; every register is loaded from here.
  always_comb begin
    w_state     = r_state;
    w_seg       = r_seg;
    w_a         = r_a;
    w_b         = r_b;
    w_sum       = r_sum;
    w_cout      = r_cout;
    w_ovf       = r_ovf;
    w_out_valid = r_out_valid;
    w_in_ready  = r_in_ready;
    w_chain_s   = r_chain_s;
    w_chain_d   = r_chain_d;
    w_chain_ci  = r_chain_ci;
    w_beff_in   = bus.in_sub ? ~bus.in_b : bus.in_b;
    w_ci_in     = bus.in_sub ? 1'b1 : bus.in_cin;
    w_nxt_idx   = 32'(r_seg) + 32'd1;

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          // Chain outputs are preloaded with pass 0 so the segment sees them in the first RUN cycle.
          w_a        = bus.in_a;
          w_b        = w_beff_in;
          w_seg      = '0;
          w_chain_s  = seg_slice(bus.in_a, 0) ^ seg_slice(w_beff_in, 0);
          w_chain_d  = seg_slice(bus.in_a, 0);
          w_chain_ci = w_ci_in;
          w_in_ready = 1'b0;
          w_state    = S_RUN;
        end
      end

      S_RUN: begin
        w_sum[32'(r_seg)*SEG_W +: SEG_W] = bus.chain_sum;
        if (r_seg == SEG_CW'(NSEG - 1)) begin
          w_cout      = bus.chain_co;
          w_ovf       = (r_a[W-1] == r_b[W-1]) & (bus.chain_sum[SEG_W-1] != r_a[W-1]);
          w_out_valid = 1'b1;
          w_seg       = '0;
          w_chain_s   = '0;
          w_chain_d   = '0;
          w_chain_ci  = 1'b0;
          w_state     = S_DONE;
        end else begin
          w_seg      = r_seg + SEG_CW'(1);
          w_chain_s  = seg_slice(r_a, w_nxt_idx) ^ seg_slice(r_b, w_nxt_idx);
          w_chain_d  = seg_slice(r_a, w_nxt_idx);
          w_chain_ci = bus.chain_co;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          w_out_valid = 1'b0;
          w_in_ready  = 1'b1;
          w_state     = S_IDLE;
        end
      end

      default: begin
        w_state    = S_IDLE;
        w_in_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_seg       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_chain_s   <= '0;
      r_chain_d   <= '0;
      r_chain_ci  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_seg       <= w_seg;
      r_a         <= w_a;
      r_b         <= w_b;
      r_sum       <= w_sum;
      r_cout      <= w_cout;
      r_ovf       <= w_ovf;
      r_out_valid <= w_out_valid;
      r_in_ready  <= w_in_ready;
      r_chain_s   <= w_chain_s;
      r_chain_d   <= w_chain_d;
      r_chain_ci  <= w_chain_ci;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.out_ovf   = r_ovf;
  assign bus.chain_s   = r_chain_s;
  assign bus.chain_d   = r_chain_d;
  assign bus.chain_ci  = r_chain_ci;

endmodule
